sram_req_arbiter: RTL

SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

---
 rtl/sram_req_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: merges an instruction and a data SRAM-style requester onto
// one bridge port. Data wins by default; instruction is forced through after
// STARVE_LIM consecutive data grants while it waits. A grant that the bridge
// stalls is locked until accepted. An in-order id queue routes each response
// back to the requester that issued it.
//
// Ports
//   clk, rstn                      clock, async active-low reset
//   {inst,data}_req/wr/size/addr/wdata   requester transaction fields
//   {inst,data}_addr_ok            request accepted this cycle
//   {inst,data}_data_ok/rdata      response for the requester's oldest txn
//   m_req/wr/size/addr/wdata       merged request to the bridge
//   m_addr_ok, m_data_ok, m_rdata  bridge accept / in-order response
//   busy                           transactions outstanding or grant locked
//   resp_err                       sticky: response with nothing outstanding
module sram_req_arbiter #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,

    output logic        busy,
    output logic        resp_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SC_W  = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    logic [DEPTH-1:0] r_q;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_lock_valid;
    logic             r_lock_src;
    logic [SC_W-1:0]  r_starve_cnt;
    logic             r_resp_err;

    logic w_full;
    logic w_empty;
    logic w_starved;
    logic w_grant;
    logic w_push;
    logic w_pop;
    logic w_head;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_starved = (r_starve_cnt == SC_W'(STARVE_LIM));
    assign w_head    = r_q[r_rptr];

    // Grant select: a held lock overrides everything, else data-first with starvation override
    always_comb begin
        w_grant = SRC_DATA;
        if (r_lock_valid) begin
            w_grant = r_lock_src;
        end else if (inst_req && (!data_req || w_starved)) begin
            w_grant = SRC_INST;
        end
    end

    // Zero-latency request path
    assign m_req   = (inst_req | data_req) & ~w_full;
    assign m_wr    = (w_grant == SRC_DATA) ? data_wr    : inst_wr;
    assign m_size  = (w_grant == SRC_DATA) ? data_size  : inst_size;
    assign m_addr  = (w_grant == SRC_DATA) ? data_addr  : inst_addr;
    assign m_wdata = (w_grant == SRC_DATA) ? data_wdata : inst_wdata;

    assign w_push = m_req & m_addr_ok;
    assign w_pop  = m_data_ok & ~w_empty;

    assign inst_addr_ok = w_push & (w_grant == SRC_INST);
    assign data_addr_ok = w_push & (w_grant == SRC_DATA);

    assign inst_data_ok = w_pop & (w_head == SRC_INST);
    assign data_data_ok = w_pop & (w_head == SRC_DATA);
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;

    assign busy     = ~w_empty | r_lock_valid;
    assign resp_err = r_resp_err;

    // Order queue of source ids; a full queue blocks m_req so push+pop never meet at full
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q     <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_q[r_wptr] <= w_grant;
                r_wptr      <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Grant lock: stalled request keeps its grant; untouched while m_req is low (e.g. full)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lock_valid <= 1'b0;
            r_lock_src   <= SRC_DATA;
        end else if (m_req) begin
            r_lock_valid <= ~m_addr_ok;
            r_lock_src   <= w_grant;
        end
    end

    // Consecutive data grants while inst waits
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_starve_cnt <= '0;
        end else if (!inst_req) begin
            r_starve_cnt <= '0;
        end else if (w_push) begin
            if (w_grant == SRC_INST) begin
                r_starve_cnt <= '0;
            end else if (!w_starved) begin
                r_starve_cnt <= r_starve_cnt + SC_W'(1);
            end
        end
    end

    // Response with no outstanding id is a protocol error, held until reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_resp_err <= 1'b0;
        end else if (m_data_ok && w_empty) begin
            r_resp_err <= 1'b1;
        end
    end

endmodule
